// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, MEM-stage state encoding and the
// EX/MEM payload layout.
package cpu_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_LW = 4'b1000;
  localparam logic [OPW-1:0] OP_SW = 4'b1001;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [15:0]    alu_out;
    logic [15:0]    store_data;
    logic [3:0]     rd;
    logic           reg_write;
  } ex_mem_t;

  function automatic logic is_mem_op(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: payload plus valid bit, held while the stage stalls.
module ex_mem_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  input  logic    valid_i,
  input  ex_mem_t data_i,
  output logic    valid_o,
  output ex_mem_t data_o
);

  logic    valid_q;
  ex_mem_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM latch, LW/SW handshake with a variable-latency data
// memory (with request timeout), MEM/WB register and a non-load forward path.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  logic           flush,
  input  logic [OPW-1:0] ex_opcode,
  input  logic [15:0]    ex_alu_out,
  input  logic [15:0]    ex_store_data,
  input  logic [3:0]     ex_rd,
  input  logic           ex_reg_write,
  output logic           mem_stall,
  output logic           mem_req,
  output logic           mem_we,
  output logic [15:0]    mem_addr,
  output logic [15:0]    mem_wdata,
  input  logic [15:0]    mem_rdata,
  input  logic           mem_ready,
  output logic           fwd_valid,
  output logic [3:0]     fwd_rd,
  output logic [15:0]    fwd_data,
  output logic           wb_valid,
  output logic           wb_reg_write,
  output logic [3:0]     wb_rd,
  output logic [15:0]    wb_data,
  output logic           mem_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          em_valid;
  ex_mem_t       em;
  ex_mem_t       ex_in;

  logic          in_req, timeout_hit, accept_mem;
  logic          wb_valid_q, wb_rw_q, wb_rw_d;
  logic [3:0]    wb_rd_q;
  logic [15:0]   wb_data_q, wb_data_d;

  assign ex_in = '{opcode: ex_opcode, alu_out: ex_alu_out, store_data: ex_store_data,
                   rd: ex_rd, reg_write: ex_reg_write};

  ex_mem_reg u_ex_mem (
    .clk     (clk),
    .rst     (rst),
    .en_i    (~mem_stall),
    .valid_i (ex_valid & ~flush),
    .data_i  (ex_in),
    .valid_o (em_valid),
    .data_o  (em)
  );

  assign in_req      = (state_q == REQ);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);
  // Combinational so a zero-wait memory completes in the request cycle.
  assign mem_stall   = in_req & ~(mem_ready | timeout_hit);
  assign accept_mem  = ex_valid & ~flush & is_mem_op(ex_opcode);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (mem_stall) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d   = '0;
      state_d = accept_mem ? REQ : IDLE;
    end
    // A ready response in the last allowed cycle beats the timeout.
    if (in_req && !mem_ready && timeout_hit) err_d = 1'b1;
  end

  always_comb begin
    wb_rw_d   = em_valid & em.reg_write & (em.opcode != OP_SW);
    wb_data_d = em.alu_out;
    if (em.opcode == OP_LW) wb_data_d = mem_ready ? mem_rdata : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (!mem_stall) begin
        wb_valid_q <= em_valid;
        wb_rw_q    <= wb_rw_d;
        wb_rd_q    <= em.rd;
        wb_data_q  <= wb_data_d;
      end
    end
  end

  assign mem_req      = in_req;
  assign mem_we       = in_req & (em.opcode == OP_SW);
  assign mem_addr     = in_req ? em.alu_out : 16'h0000;
  assign mem_wdata    = in_req ? em.store_data : 16'h0000;

  assign fwd_valid    = em_valid & em.reg_write & (em.opcode != OP_LW);
  assign fwd_rd       = em.rd;
  assign fwd_data     = em.alu_out;

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scenarios followed by randomized traffic against a transaction-level
// model of the stage and a TB-owned memory with random response latency.
module tb_mem_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush, ex_reg_write;
  logic [3:0]  ex_opcode, ex_rd;
  logic [15:0] ex_alu_out, ex_store_data;
  logic        mem_stall, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        wb_valid, wb_reg_write;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mem_err;

  int passed = 0;
  int total  = 0;

  // reference model state
  logic [15:0] memarr [256];
  logic        m_v, m_rw, m_wbv, m_wbrw, m_is_mem, m_ready, exp_stall, exp_fwd;
  logic [3:0]  m_op, m_rd, m_wbrd;
  logic [15:0] m_alu, m_sd, m_wbd;
  int          m_w, m_lat;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush), .ex_opcode(ex_opcode),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [3:0] rd, input logic rw);
    ex_valid = 1'b1; ex_opcode = op; ex_alu_out = alu; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, mem_stall, 0);
    check({tag, ".req"}, mem_req, 0);
    check({tag, ".we"}, mem_we, 0);
    check({tag, ".addr"}, mem_addr, 0);
    check({tag, ".wdata"}, mem_wdata, 0);
    check({tag, ".fwd_valid"}, fwd_valid, 0);
    check({tag, ".fwd_rd"}, fwd_rd, 0);
    check({tag, ".fwd_data"}, fwd_data, 0);
    check({tag, ".wb_valid"}, wb_valid, 0);
    check({tag, ".wb_rw"}, wb_reg_write, 0);
    check({tag, ".wb_rd"}, wb_rd, 0);
    check({tag, ".wb_data"}, wb_data, 0);
    check({tag, ".err"}, mem_err, 0);
  endtask

  initial begin
    int reqc, stc, r;
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
    set_ex(OP_LW, 16'h0040, 16'h1111, 4'd5, 1'b1);

    // reset held two cycles with a valid LW presented
    tick();
    @(negedge clk); check_all_zero("rst1");
    tick();
    @(negedge clk); check_all_zero("rst2");
    tick();
    rst = 1'b0; ex_valid = 1'b0;

    // ALU op: forward next cycle, write-back the cycle after
    set_ex(4'b0000, 16'h1234, 16'h0, 4'd3, 1'b1);
    tick(); ex_valid = 1'b0;
    @(negedge clk);
    check("alu.fwd_valid", fwd_valid, 1); check("alu.fwd_rd", fwd_rd, 3);
    check("alu.fwd_data", fwd_data, 16'h1234); check("alu.stall", mem_stall, 0);
    tick();
    @(negedge clk);
    check("alu.wb_valid", wb_valid, 1); check("alu.wb_rd", wb_rd, 3);
    check("alu.wb_data", wb_data, 16'h1234); check("alu.wb_rw", wb_reg_write, 1);

    // LW zero-wait
    set_ex(OP_LW, 16'h0040, 16'h0, 4'd7, 1'b1);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk); check("lw0.stall_pre", mem_stall, 0);
    tick(); ex_valid = 1'b0;
    @(negedge clk);
    check("lw0.req", mem_req, 1); check("lw0.addr", mem_addr, 16'h0040);
    check("lw0.we", mem_we, 0); check("lw0.stall", mem_stall, 0); check("lw0.fwd", fwd_valid, 0);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    check("lw0.wb_valid", wb_valid, 1); check("lw0.wb_data", wb_data, 16'hBEEF);
    check("lw0.wb_rw", wb_reg_write, 1); check("lw0.req_after", mem_req, 0);

    // SW with 3 wait states; a new ALU op waits behind it
    set_ex(OP_SW, 16'h0010, 16'hA5A5, 4'd2, 1'b1);
    tick();
    set_ex(4'b0010, 16'hFFFF, 16'h5A5A, 4'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      check("sw3.req", mem_req, 1); check("sw3.we", mem_we, 1);
      check("sw3.addr", mem_addr, 16'h0010); check("sw3.wdata", mem_wdata, 16'hA5A5);
      check("sw3.stall", mem_stall, (i < 3));
      tick();
    end
    mem_ready = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    check("sw3.wb_valid", wb_valid, 1); check("sw3.wb_rw", wb_reg_write, 0);
    check("sw3.req_after", mem_req, 0);
    check("sw3.next_fwd_rd", fwd_rd, 9); check("sw3.next_fwd_data", fwd_data, 16'hFFFF);
    tick();

    // reset in the third wait cycle of an SW
    set_ex(OP_SW, 16'h0020, 16'h7777, 4'd1, 1'b0);
    tick(); ex_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rstmid.req", mem_req, 0); check("rstmid.stall", mem_stall, 0);
    check("rstmid.wb_valid", wb_valid, 0); check("rstmid.err", mem_err, 0);

    // timeout: LW never answered
    set_ex(OP_LW, 16'h0022, 16'h0, 4'd4, 1'b1);
    mem_rdata = 16'hDEAD;
    tick(); ex_valid = 1'b0;
    reqc = 0; stc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!mem_req) break;
      reqc++;
      if (mem_stall) stc++;
      tick();
    end
    check("to.req_cycles", reqc, 15); check("to.stall_cycles", stc, 14);
    check("to.err", mem_err, 1); check("to.wb_valid", wb_valid, 1);
    check("to.wb_data", wb_data, 16'h0000);
    tick(); tick(); tick();
    @(negedge clk); check("to.err_sticky", mem_err, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); check("to.err_cleared", mem_err, 0);

    // randomized traffic against the model
    for (int i = 0; i < 256; i++) memarr[i] = 16'($urandom);
    m_v = 0; m_rw = 0; m_op = 0; m_rd = 0; m_alu = 0; m_sd = 0; m_w = 0; m_lat = 0;
    m_wbv = 0; m_wbrw = 0; m_wbrd = 0; m_wbd = 0;
    tick();
    for (int cyc = 0; cyc < 500; cyc++) begin
      ex_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 3);
      ex_opcode = (r == 0) ? OP_LW : (r == 1) ? OP_SW : 4'($urandom_range(0, 15));
      ex_alu_out = 16'($urandom); ex_store_data = 16'($urandom);
      ex_rd = 4'($urandom); ex_reg_write = 1'($urandom);
      m_is_mem = m_v && (m_op == OP_LW || m_op == OP_SW);
      m_ready = m_is_mem && (m_w == m_lat);
      exp_stall = m_is_mem && !m_ready;
      exp_fwd = m_v && m_rw && (m_op != OP_LW);
      mem_ready = m_ready;
      mem_rdata = (m_ready && m_op == OP_LW) ? memarr[m_alu[7:0]] : 16'($urandom);
      @(negedge clk);
      check("rnd.stall", mem_stall, exp_stall);
      check("rnd.req", mem_req, m_is_mem);
      if (m_is_mem) begin
        check("rnd.we", mem_we, (m_op == OP_SW));
        check("rnd.addr", mem_addr, m_alu);
        if (m_op == OP_SW) check("rnd.wdata", mem_wdata, m_sd);
      end
      check("rnd.fwd_valid", fwd_valid, exp_fwd);
      if (exp_fwd) begin
        check("rnd.fwd_rd", fwd_rd, m_rd); check("rnd.fwd_data", fwd_data, m_alu);
      end
      check("rnd.wb_valid", wb_valid, m_wbv);
      if (m_wbv) begin
        check("rnd.wb_rd", wb_rd, m_wbrd); check("rnd.wb_data", wb_data, m_wbd);
        check("rnd.wb_rw", wb_reg_write, m_wbrw);
      end
      check("rnd.err", mem_err, 0);
      @(posedge clk);
      if (exp_stall) begin
        m_w++;
      end else begin
        m_wbv = m_v; m_wbrd = m_rd; m_wbrw = m_rw && (m_op != OP_SW);
        m_wbd = (m_op == OP_LW) ? memarr[m_alu[7:0]] : m_alu;
        if (m_v && m_op == OP_SW) memarr[m_alu[7:0]] = m_sd;
        m_v = ex_valid && !flush; m_op = ex_opcode; m_alu = ex_alu_out; m_sd = ex_store_data;
        m_rd = ex_rd; m_rw = ex_reg_write;
        m_w = 0; m_lat = $urandom_range(0, 3);
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
